shift_arbiter: RTL and testbench

- Shares the single 32-bit barrel `shifter` in EXE between two requesters:
  - requester 0: the ALU shift path (SLL/SRL/SRA, SLLI/SRLI/SRAI);
  - requester 1: the multiply/divide unit (operand normalisation and alignment).
- Arbitrates round-robin or fixed-priority, drives the shifter from the granted operands, and registers the result into a one-entry output buffer.
- The buffer is drained by the owning requester through a valid/ready handshake.
- A pipeline flush from the branch logic kills in-flight requester-0 work only.

---
 rtl/shift_pkg.sv | 33 +++
 rtl/shift_arbiter_shifter.sv | 43 ++++
 rtl/shift_arbiter.sv | 150 +++++++++++++++
 tb/tb_shift_arbiter.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_pkg.sv
// Purpose : shared command encodings, requester ids and helpers for the EXE shift path.
// Latency : n/a (types, constants and a pure function only).
// Backpressure: n/a.
package shift_pkg;

  // Shift command encoding. CMD[1] selects sign fill, and any nonzero CMD shifts
  // right, so the spare code 2'b11 behaves exactly like SRA.
  localparam logic [1:0] SHIFT_SLL = 2'b00;
  localparam logic [1:0] SHIFT_SRL = 2'b01;
  localparam logic [1:0] SHIFT_SRA = 2'b10;

  typedef enum logic {
    REQ_ALU    = 1'b0,
    REQ_MULDIV = 1'b1
  } req_id_e;

  // One shift operation as presented by a requester.
  typedef struct packed {
    logic [31:0] din;
    logic [4:0]  shamt;
    logic [1:0]  cmd;
  } shift_op_t;

  // Bit reversal lets a single right-shifting network also perform left shifts.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shift_arbiter_shifter.sv
// Purpose : combinational 32-bit barrel shifter (SLL / SRL / SRA).
// Latency : 0 cycles, purely combinational.
// Backpressure: none; the output follows the inputs.
//
// Ports:
//   DIN_SE       [31:0] operand
//   SHIFT_VAL_SE [4:0]  shift amount
//   CMD_SE       [1:0]  command (shift_pkg encoding)
//   DOUT_SE      [31:0] shifted result
module shifter
  import shift_pkg::*;
(
  input  logic [31:0] DIN_SE,
  input  logic [4:0]  SHIFT_VAL_SE,
  input  logic [1:0]  CMD_SE,
  output logic [31:0] DOUT_SE
);

  localparam logic [31:0] ALL_ONES = '1;

  logic        shift_right;
  logic        fill_bit;
  logic [31:0] stage_v;

  // Any nonzero command shifts right. Sign fill is used only when CMD[1] is
  // set. For SLL CMD[1] is 0, so the fill is always zero for left shifts.
  assign shift_right = |CMD_SE;
  assign fill_bit    = CMD_SE[1] & DIN_SE[31];

  // Log shifter: five conditional right-shift stages of 1, 2, 4, 8 and 16
  // bits. A left shift reverses the operand on the way in and on the way out.
  always_comb begin
    stage_v = shift_right ? DIN_SE : bit_rev32(DIN_SE);
    for (int k = 0; k < 5; k++) begin
      if (SHIFT_VAL_SE[k]) begin
        stage_v = (stage_v >> (1 << k)) | (~(ALL_ONES >> (1 << k)) & {32{fill_bit}});
      end
    end
  end

  assign DOUT_SE = shift_right ? stage_v : bit_rev32(stage_v);

endmodule

// File: rtl/shift_arbiter.sv
// Purpose : shares one barrel shifter between the ALU (req 0) and mul/div (req 1)
//           and holds the result in a one-entry output buffer.
// Latency : 1 cycle. A request accepted at edge N is valid from N+1.
//           Sustains 1 op/cycle while the owner drains.
// Backpressure: a held buffer (owner not ready) blocks all new acceptances.
//           A flush empties a req-0 entry and blocks req-0 requests.
//
// Ports:
//   CLK, RESET_N                  clock, synchronous active-low reset
//   FLUSH_SA                      pipeline flush; kills requester-0 traffic only
//   REQx_VALID/DIN/SHAMT/CMD_SA   requester x operation (hold while READY=0)
//   REQx_READY_SA                 requester x accepted this cycle
//   RESx_VALID_SA                 buffered result belongs to requester x
//   RES_DATA_SA                   buffered shift result (shared)
//   RESx_READY_SA                 requester x consumes the result
module shift_arbiter
  import shift_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        FLUSH_SA,

  input  logic        REQ0_VALID_SA,
  input  logic [31:0] REQ0_DIN_SA,
  input  logic [4:0]  REQ0_SHAMT_SA,
  input  logic [1:0]  REQ0_CMD_SA,
  output logic        REQ0_READY_SA,

  input  logic        REQ1_VALID_SA,
  input  logic [31:0] REQ1_DIN_SA,
  input  logic [4:0]  REQ1_SHAMT_SA,
  input  logic [1:0]  REQ1_CMD_SA,
  output logic        REQ1_READY_SA,

  output logic        RES0_VALID_SA,
  output logic        RES1_VALID_SA,
  output logic [31:0] RES_DATA_SA,
  input  logic        RES0_READY_SA,
  input  logic        RES1_READY_SA
);

  // Output buffer and arbitration state.
  logic        full_q,  full_d;
  req_id_e     owner_q, owner_d;
  logic [31:0] data_q,  data_d;
  req_id_e     last_q,  last_d;

  logic        elig0, elig1, contend;
  logic        grant0, grant1;
  logic        res0_vld, res1_vld;
  logic        drained, flush_kill, free_buf;
  logic        acc0, acc1;

  shift_op_t   op0, op1, op_sel;
  logic [31:0] shift_out;

  assign res0_vld = full_q & (owner_q == REQ_ALU);
  assign res1_vld = full_q & (owner_q == REQ_MULDIV);

  // A requester-0 entry that is flushed does not count as drained, even if
  // RES0_READY is high. This keeps requester 1 out of the flush cycle.
  assign drained    = (res0_vld & RES0_READY_SA & ~FLUSH_SA) | (res1_vld & RES1_READY_SA);
  assign flush_kill = res0_vld & FLUSH_SA;
  assign free_buf   = ~full_q | drained;

  assign elig0   = REQ0_VALID_SA & ~FLUSH_SA;
  assign elig1   = REQ1_VALID_SA;
  assign contend = elig0 & elig1;

  // Round-robin: on contention the requester not recorded in last_q wins.
  // Fixed priority: requester 0 wins whenever it is eligible.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (FIXED_PRIO) begin
      grant0 = elig0;
      grant1 = elig1 & ~elig0;
    end else if (contend) begin
      grant0 = (last_q == REQ_MULDIV);
      grant1 = (last_q == REQ_ALU);
    end else begin
      grant0 = elig0;
      grant1 = elig1;
    end
  end

  assign acc0 = grant0 & free_buf;
  assign acc1 = grant1 & free_buf;

  assign REQ0_READY_SA = acc0;
  assign REQ1_READY_SA = acc1;

  assign op0 = '{din: REQ0_DIN_SA, shamt: REQ0_SHAMT_SA, cmd: REQ0_CMD_SA};
  assign op1 = '{din: REQ1_DIN_SA, shamt: REQ1_SHAMT_SA, cmd: REQ1_CMD_SA};

  // Requester 0 is the default source when nobody is granted. The result is
  // only captured on acceptance, so the idle choice does not matter.
  assign op_sel = grant1 ? op1 : op0;

  shifter u_shifter (
    .DIN_SE       (op_sel.din),
    .SHIFT_VAL_SE (op_sel.shamt),
    .CMD_SE       (op_sel.cmd),
    .DOUT_SE      (shift_out)
  );

  always_comb begin
    full_d  = full_q;
    owner_d = owner_q;
    data_d  = data_q;
    last_d  = last_q;

    if (flush_kill | drained) begin
      full_d = 1'b0;
    end

    // Refill takes priority over drain on the same edge. Acceptance implies
    // free_buf, so it can never coincide with a flush of a held req-0 entry.
    if (acc0 | acc1) begin
      full_d  = 1'b1;
      owner_d = acc1 ? REQ_MULDIV : REQ_ALU;
      data_d  = shift_out;
      // last_q only moves on contended round-robin grants.
      if (!FIXED_PRIO && contend) begin
        last_d = acc1 ? REQ_MULDIV : REQ_ALU;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      full_q  <= 1'b0;
      owner_q <= REQ_ALU;
      data_q  <= '0;
      last_q  <= REQ_MULDIV;
    end else begin
      full_q  <= full_d;
      owner_q <= owner_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

  assign RES0_VALID_SA = res0_vld;
  assign RES1_VALID_SA = res1_vld;
  assign RES_DATA_SA   = data_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Purpose : directed scoreboard bench for shift_arbiter (round-robin and fixed-priority instances).
// Latency : expectations are queued when a request is accepted and popped on each drained result.
// Backpressure: exercised through held RESx_READY, flush and mid-operation reset.
module tb_shift_arbiter;

  typedef struct {
    bit          owner;
    logic [31:0] data;
  } exp_t;

  logic        CLK;
  logic        RESET_N;
  logic        flush;
  logic        r0v, r1v;
  logic [31:0] r0d, r1d;
  logic [4:0]  r0s, r1s;
  logic [1:0]  r0c, r1c;
  logic        res0r, res1r;

  logic        r0rdy, r1rdy, res0v, res1v;
  logic [31:0] resd;
  logic        fp_r0rdy, fp_r1rdy, fp_res0v, fp_res1v;
  logic [31:0] fp_resd;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t sb_q[$];

  shift_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH_SA(flush),
    .REQ0_VALID_SA(r0v), .REQ0_DIN_SA(r0d), .REQ0_SHAMT_SA(r0s), .REQ0_CMD_SA(r0c),
    .REQ0_READY_SA(r0rdy),
    .REQ1_VALID_SA(r1v), .REQ1_DIN_SA(r1d), .REQ1_SHAMT_SA(r1s), .REQ1_CMD_SA(r1c),
    .REQ1_READY_SA(r1rdy),
    .RES0_VALID_SA(res0v), .RES1_VALID_SA(res1v), .RES_DATA_SA(resd),
    .RES0_READY_SA(res0r), .RES1_READY_SA(res1r)
  );

  shift_arbiter #(.FIXED_PRIO(1'b1)) u_fp (
    .CLK(CLK), .RESET_N(RESET_N), .FLUSH_SA(flush),
    .REQ0_VALID_SA(r0v), .REQ0_DIN_SA(r0d), .REQ0_SHAMT_SA(r0s), .REQ0_CMD_SA(r0c),
    .REQ0_READY_SA(fp_r0rdy),
    .REQ1_VALID_SA(r1v), .REQ1_DIN_SA(r1d), .REQ1_SHAMT_SA(r1s), .REQ1_CMD_SA(r1c),
    .REQ1_READY_SA(fp_r1rdy),
    .RES0_VALID_SA(fp_res0v), .RES1_VALID_SA(fp_res1v), .RES_DATA_SA(fp_resd),
    .RES0_READY_SA(res0r), .RES1_READY_SA(res1r)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk1(input string name, input logic act, input logic exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, want %b", name, act, exp);
    end
  endtask

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic push(input bit owner, input logic [31:0] data);
    exp_t e;
    e.owner = owner;
    e.data  = data;
    sb_q.push_back(e);
  endtask

  task automatic pop_cmp(input bit owner);
    exp_t e;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL sb_unexpected: got result owner %0d data 0x%08h, want none", owner, resd);
    end else begin
      e = sb_q.pop_front();
      chk1("sb_owner", owner, e.owner);
      chk32("sb_data", resd, e.data);
    end
  endtask

  // Monitor: every result the owning requester actually consumes is checked
  // against the oldest queued expectation. Flushed entries are never queued.
  always @(negedge CLK) begin
    if (RESET_N === 1'b1) begin
      if (res0v === 1'b1 && res0r === 1'b1 && flush === 1'b0) pop_cmp(1'b0);
      if (res1v === 1'b1 && res1r === 1'b1) pop_cmp(1'b1);
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  initial begin
    RESET_N = 1'b0; flush = 1'b0;
    r0v = 1'b0; r0d = '0; r0s = '0; r0c = '0;
    r1v = 1'b0; r1d = '0; r1s = '0; r1c = '0;
    res0r = 1'b0; res1r = 1'b0;

    // Reset state
    tick(); tick();
    smp();
    chk1("rst_res0_valid", res0v, 1'b0);
    chk1("rst_res1_valid", res1v, 1'b0);
    chk32("rst_res_data", resd, 32'h0);
    tick();
    RESET_N = 1'b1;

    // Requester 0 SLL
    r0v = 1'b1; r0d = 32'h0000_00F0; r0s = 5'd4; r0c = 2'b00; res0r = 1'b1; res1r = 1'b1;
    push(1'b0, 32'h0000_0F00);
    smp();
    chk1("t1_req0_ready", r0rdy, 1'b1);
    chk1("t1_req1_ready", r1rdy, 1'b0);
    tick();
    r0v = 1'b0;
    smp();
    chk1("t1_res0_valid", res0v, 1'b1);
    chk1("t1_res1_valid", res1v, 1'b0);
    tick();
    smp();
    chk1("t1_res1_valid_after", res1v, 1'b0);
    tick();

    // Requester 1 right shifts: SRA, SRL, CMD=11
    r1v = 1'b1; r1d = 32'h8000_0000; r1s = 5'd31; r1c = 2'b10;
    push(1'b1, 32'hFFFF_FFFF);
    smp();
    chk1("t2_req1_ready", r1rdy, 1'b1);
    tick();
    r1c = 2'b01;
    push(1'b1, 32'h0000_0001);
    smp();
    chk1("t2_res1_valid", res1v, 1'b1);
    chk1("t2_req1_ready_srl", r1rdy, 1'b1);
    tick();
    r1c = 2'b11;
    push(1'b1, 32'hFFFF_FFFF);
    smp();
    chk1("t2_req1_ready_cmd11", r1rdy, 1'b1);
    tick();
    r1v = 1'b0;
    smp();
    tick();

    // Contention: round-robin alternates 0,1,0,1 and fixed priority always picks requester 0
    r0v = 1'b1; r0d = 32'h0000_0001; r0s = 5'd1; r0c = 2'b00;
    r1v = 1'b1; r1d = 32'h0000_0100; r1s = 5'd4; r1c = 2'b01;
    for (int i = 0; i < 4; i++) begin
      bit exp0;
      exp0 = ((i % 2) == 0);
      if (exp0) push(1'b0, 32'h0000_0002);
      else      push(1'b1, 32'h0000_0010);
      smp();
      chk1("t3_rr_req0_ready", r0rdy, exp0);
      chk1("t3_rr_req1_ready", r1rdy, ~exp0);
      chk1("t3_fp_req0_ready", fp_r0rdy, 1'b1);
      chk1("t3_fp_req1_ready", fp_r1rdy, 1'b0);
      if (i > 0) begin
        chk1("t3_fp_res0_valid", fp_res0v, 1'b1);
        chk1("t3_fp_res1_valid", fp_res1v, 1'b0);
        chk32("t3_fp_res_data", fp_resd, 32'h0000_0002);
      end
      tick();
    end
    r0v = 1'b0; r1v = 1'b0;
    smp();
    tick();

    // Back-pressure with 0x1234_5678 held for three cycles
    res0r = 1'b0; res1r = 1'b0;
    r0v = 1'b1; r0d = 32'h1234_5678; r0s = 5'd0; r0c = 2'b00;
    push(1'b0, 32'h1234_5678);
    smp();
    chk1("t5_req0_ready", r0rdy, 1'b1);
    tick();
    r0d = 32'h0000_0001; r0s = 5'd8;
    r1v = 1'b1; r1d = 32'h0000_000F; r1s = 5'd4; r1c = 2'b00;
    for (int i = 0; i < 3; i++) begin
      smp();
      chk1("t5_hold_res0_valid", res0v, 1'b1);
      chk32("t5_hold_data", resd, 32'h1234_5678);
      chk1("t5_hold_req0_ready", r0rdy, 1'b0);
      chk1("t5_hold_req1_ready", r1rdy, 1'b0);
      tick();
    end
    res0r = 1'b1;
    push(1'b0, 32'h0000_0100);
    smp();
    chk1("t5_release_req0_ready", r0rdy, 1'b1);
    chk1("t5_release_req1_ready", r1rdy, 1'b0);
    tick();
    r0v = 1'b0; res1r = 1'b1;
    push(1'b1, 32'h0000_00F0);
    smp();
    chk1("t5_req1_ready", r1rdy, 1'b1);
    tick();
    r1v = 1'b0;
    smp();
    tick();

    // Flush kills a held req-0 result and blocks req 0 and req 1 in that cycle
    res0r = 1'b0; res1r = 1'b0;
    r0v = 1'b1; r0d = 32'h0000_00AA; r0s = 5'd0; r0c = 2'b00;
    smp();
    chk1("t6_req0_ready", r0rdy, 1'b1);
    tick();
    flush = 1'b1; r0d = 32'h0000_00BB; res0r = 1'b1;
    r1v = 1'b1; r1d = 32'h0000_0003; r1s = 5'd1; r1c = 2'b00;
    smp();
    chk1("t6_flush_req0_ready", r0rdy, 1'b0);
    chk1("t6_flush_req1_ready", r1rdy, 1'b0);
    chk1("t6_flush_res0_valid", res0v, 1'b1);
    tick();
    flush = 1'b0; r0v = 1'b0; res0r = 1'b0;
    smp();
    chk1("t6_res0_flushed", res0v, 1'b0);
    chk1("t6_req1_ready_after", r1rdy, 1'b1);
    push(1'b1, 32'h0000_0006);
    tick();
    // Flush must leave a held req-1 result alone
    r1v = 1'b0; flush = 1'b1;
    smp();
    chk1("t6_res1_during_flush", res1v, 1'b1);
    tick();
    flush = 1'b0; res1r = 1'b1;
    smp();
    chk1("t6_res1_survives", res1v, 1'b1);
    chk32("t6_res1_data", resd, 32'h0000_0006);
    tick();
    res1r = 1'b0;
    smp();
    chk1("t6_res1_drained", res1v, 1'b0);
    tick();

    // Reset while a result is held and both requests are pending
    r0v = 1'b1; r0d = 32'h0000_0055; r0s = 5'd1; r0c = 2'b00;
    smp();
    chk1("t7_req0_ready", r0rdy, 1'b1);
    tick();
    r0d = 32'h0000_0001; r0s = 5'd2;
    r1v = 1'b1; r1d = 32'h8000_0000; r1s = 5'd1; r1c = 2'b01;
    RESET_N = 1'b0;
    smp();
    tick();
    RESET_N = 1'b1; res0r = 1'b1; res1r = 1'b1;
    push(1'b0, 32'h0000_0004);
    smp();
    chk1("t7_res0_valid", res0v, 1'b0);
    chk1("t7_res1_valid", res1v, 1'b0);
    chk32("t7_res_data", resd, 32'h0);
    chk1("t7_first_grant_req0", r0rdy, 1'b1);
    chk1("t7_first_grant_req1", r1rdy, 1'b0);
    tick();
    r0v = 1'b0;
    push(1'b1, 32'h4000_0000);
    smp();
    chk1("t7_req1_ready", r1rdy, 1'b1);
    tick();
    r1v = 1'b0;
    smp();
    tick();
    smp();
    tick();

    smp();
    chk32("sb_empty", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
